// File: rtl/lc3b_types_pkg.sv
// rtl/lc3b_types_pkg.sv - shared LC-3b datapath types and memory-op helpers
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [2:0] {
      MEM_NONE,
      MEM_LDR,
      MEM_LDB,
      MEM_STR,
      MEM_STB,
      MEM_LDI,
      MEM_STI
   } lc3b_memop;

   function automatic logic is_indirect(input lc3b_memop op);
      return (op == MEM_LDI) || (op == MEM_STI);
   endfunction

   function automatic logic is_store(input lc3b_memop op);
      return (op == MEM_STR) || (op == MEM_STB) || (op == MEM_STI);
   endfunction

   function automatic lc3b_word word_align(input lc3b_word a);
      return {a[15:1], 1'b0};
   endfunction

endpackage

// File: rtl/mem_byte_align.sv
// rtl/mem_byte_align.sv - byte-load extraction with sign extension and byte-store lane replication
module mem_byte_align
   import lc3b_types::*;
(
   input  lc3b_word   rdata_i,
   input  lc3b_word   wdata_i,
   input  logic       byte_sel_i,
   output lc3b_word   load_byte_o,
   output lc3b_word   store_byte_o
);

   logic [7:0] sel_byte;

   assign sel_byte     = byte_sel_i ? rdata_i[15:8] : rdata_i[7:0];
   assign load_byte_o  = {{8{sel_byte[7]}}, sel_byte};
   // The store byte goes on both lanes; byte_enable picks which one lands.
   assign store_byte_o = {wdata_i[7:0], wdata_i[7:0]};

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - LC-3b memory stage: sequences direct and indirect data accesses
// and stalls the upstream pipeline until the access completes.
module mem_stage_ctrl
   import lc3b_types::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  lc3b_memop  memop_in,
   input  lc3b_word   addr_in,
   input  lc3b_word   wdata_in,
   input  lc3b_word   dmem_rdata,
   input  logic       dmem_resp,
   output lc3b_word   dmem_address,
   output logic       dmem_read,
   output logic       dmem_write,
   output logic [1:0] dmem_byte_enable,
   output lc3b_word   dmem_wdata,
   output logic       stall_out,
   output lc3b_word   mem_data_out,
   output logic       done_out
);

   typedef enum logic [1:0] {S_IDLE, S_IND, S_ACC} state_e;

   state_e    state_q, state_d;
   lc3b_memop op_q, op_d;
   lc3b_word  addr_q, addr_d;
   lc3b_word  wdata_q, wdata_d;
   logic      start;
   lc3b_word  ldb_data;
   lc3b_word  stb_data;

   assign start = valid_in && (memop_in != MEM_NONE);

   mem_byte_align u_byte_align (
      .rdata_i      (dmem_rdata),
      .wdata_i      (wdata_q),
      .byte_sel_i   (addr_q[0]),
      .load_byte_o  (ldb_data),
      .store_byte_o (stb_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= MEM_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = memop_in;
               addr_d  = addr_in;
               wdata_d = wdata_in;
               state_d = is_indirect(memop_in) ? S_IND : S_ACC;
            end
         end
         S_IND: begin
            if (dmem_resp) begin
               addr_d  = word_align(dmem_rdata);
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            if (dmem_resp) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request outputs depend only on registered state so they hold steady until dmem_resp.
   always_comb begin
      dmem_address     = '0;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_byte_enable = 2'b00;
      dmem_wdata       = '0;
      stall_out        = 1'b0;
      mem_data_out     = '0;
      done_out         = 1'b0;
      case (state_q)
         S_IDLE: stall_out = start;
         S_IND: begin
            dmem_read    = 1'b1;
            dmem_address = word_align(addr_q);
            stall_out    = 1'b1;
         end
         S_ACC: begin
            stall_out = ~dmem_resp;
            done_out  = dmem_resp;
            if (is_store(op_q)) begin
               dmem_write = 1'b1;
               if (op_q == MEM_STB) begin
                  dmem_address     = addr_q;
                  dmem_wdata       = stb_data;
                  dmem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
               end else begin
                  dmem_address     = word_align(addr_q);
                  dmem_wdata       = wdata_q;
                  dmem_byte_enable = 2'b11;
               end
            end else begin
               dmem_read    = 1'b1;
               dmem_address = (op_q == MEM_LDB) ? addr_q : word_align(addr_q);
               if (dmem_resp) mem_data_out = (op_q == MEM_LDB) ? ldb_data : dmem_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - scoreboard-based self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
   import lc3b_types::*;

   logic       clk;
   logic       reset;
   logic       valid_in;
   lc3b_memop  memop_in;
   lc3b_word   addr_in;
   lc3b_word   wdata_in;
   lc3b_word   dmem_rdata;
   logic       dmem_resp;
   lc3b_word   dmem_address;
   logic       dmem_read;
   logic       dmem_write;
   logic [1:0] dmem_byte_enable;
   lc3b_word   dmem_wdata;
   logic       stall_out;
   lc3b_word   mem_data_out;
   logic       done_out;

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_q[$];

   logic [15:0] obs_ind_addr, obs_acc_addr, obs_acc_wdata;
   logic [1:0]  obs_acc_be;
   logic        obs_start_stall;
   int          obs_stall_cnt, obs_done_cyc, obs_acc_reads, obs_acc_writes, obs_both;

   mem_stage_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .valid_in         (valid_in),
      .memop_in         (memop_in),
      .addr_in          (addr_in),
      .wdata_in         (wdata_in),
      .dmem_rdata       (dmem_rdata),
      .dmem_resp        (dmem_resp),
      .dmem_address     (dmem_address),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_byte_enable (dmem_byte_enable),
      .dmem_wdata       (dmem_wdata),
      .stall_out        (stall_out),
      .mem_data_out     (mem_data_out),
      .done_out         (done_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every completion pops the oldest expected load result.
   always @(negedge clk) begin
      if (done_out) begin
         logic [15:0] exp;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stray_done: done_out=1 with nothing pending, mem_data_out=%h", mem_data_out);
         end else begin
            exp = exp_q.pop_front();
            if (mem_data_out !== exp) begin
               errors++;
               $display("FAIL sb_mem_data: got %h expected %h", mem_data_out, exp);
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the rising edge that follows done.
   task automatic do_txn(input lc3b_memop op, input logic [15:0] a, input logic [15:0] w,
                         input logic [15:0] ptr, input int ind_waits,
                         input logic [15:0] data, input int acc_waits);
      int  phase, cnt, wt;
      bit  done;
      obs_ind_addr = '0; obs_acc_addr = '0; obs_acc_wdata = '0; obs_acc_be = '0;
      obs_stall_cnt = 0; obs_done_cyc = -1; obs_acc_reads = 0; obs_acc_writes = 0; obs_both = 0;
      valid_in = 1'b1; memop_in = op; addr_in = a; wdata_in = w; dmem_resp = 1'b0;
      @(negedge clk);
      obs_start_stall = stall_out;
      if (stall_out) obs_stall_cnt++;
      @(posedge clk); #1;
      valid_in = 1'b0; memop_in = MEM_NONE; addr_in = 16'hDEAD; wdata_in = 16'hDEAD;
      phase = (op == MEM_LDI || op == MEM_STI) ? 0 : 1;
      cnt = 0;
      done = 0;
      for (int c = 2; c <= 40 && !done; c++) begin
         wt = (phase == 0) ? ind_waits : acc_waits;
         if (cnt == wt) begin
            dmem_resp  = 1'b1;
            dmem_rdata = (phase == 0) ? ptr : data;
         end else begin
            dmem_resp  = 1'b0;
            dmem_rdata = 16'($urandom);
         end
         @(negedge clk);
         if (dmem_read && dmem_write) obs_both++;
         if (phase == 0) obs_ind_addr = dmem_address;
         else begin
            if (dmem_read)  obs_acc_reads++;
            if (dmem_write) obs_acc_writes++;
            if (dmem_resp) begin
               obs_acc_addr  = dmem_address;
               obs_acc_be    = dmem_byte_enable;
               obs_acc_wdata = dmem_wdata;
            end
         end
         if (stall_out) obs_stall_cnt++;
         if (done_out) begin
            done = 1;
            obs_done_cyc = c;
         end
         if (dmem_resp) begin
            phase = 1;
            cnt = 0;
         end else cnt++;
         if (!done) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      dmem_resp = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if ({dmem_read, dmem_write, dmem_byte_enable, stall_out, done_out} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: rd=%b wr=%b be=%b stall=%b done=%b required all 0",
                  dmem_read, dmem_write, dmem_byte_enable, stall_out, done_out);
      end
      checks++;
      if ({dmem_address, dmem_wdata, mem_data_out} !== 48'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h data=%h required 0", dmem_address, dmem_wdata, mem_data_out);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (stall_out !== 1'b0 || dmem_read !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: stall=%b rd=%b required 0", stall_out, dmem_read);
      end
   endtask

   task automatic test_ldr;
      exp_q.push_back(16'hBEEF);
      do_txn(MEM_LDR, 16'h3001, 16'h0, 16'h0, 0, 16'hBEEF, 0);
      checks++;
      if (obs_acc_addr !== 16'h3000) begin errors++; $display("FAIL ldr_addr: got %h required 3000", obs_acc_addr); end
      checks++;
      if (obs_acc_reads !== 1 || obs_acc_writes !== 0) begin
         errors++; $display("FAIL ldr_read_cycles: reads=%0d writes=%0d required 1/0", obs_acc_reads, obs_acc_writes);
      end
      checks++;
      if (obs_done_cyc !== 2) begin errors++; $display("FAIL ldr_latency: done at %0d required 2", obs_done_cyc); end
      checks++;
      if (obs_stall_cnt !== 1 || obs_start_stall !== 1'b1) begin
         errors++; $display("FAIL ldr_stall: cycles=%0d start=%b required 1/1", obs_stall_cnt, obs_start_stall);
      end
      checks++;
      if (obs_acc_be !== 2'b00) begin errors++; $display("FAIL ldr_be: got %b required 00", obs_acc_be); end
   endtask

   task automatic test_ldb;
      logic [15:0] a_tab[3] = '{16'h4003, 16'h4002, 16'h4000};
      logic [15:0] d_tab[3] = '{16'h80FF, 16'h80FF, 16'h7F12};
      logic [15:0] e_tab[3] = '{16'hFF80, 16'hFFFF, 16'h0012};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(e_tab[i]);
         do_txn(MEM_LDB, a_tab[i], 16'h0, 16'h0, 0, d_tab[i], i);
         checks++;
         if (obs_acc_addr !== a_tab[i]) begin
            errors++; $display("FAIL ldb_addr[%0d]: got %h required %h", i, obs_acc_addr, a_tab[i]);
         end
         checks++;
         if (obs_done_cyc !== 2 + i) begin
            errors++; $display("FAIL ldb_latency[%0d]: done at %0d required %0d", i, obs_done_cyc, 2 + i);
         end
      end
   endtask

   task automatic test_stores;
      exp_q.push_back(16'h0000);
      do_txn(MEM_STB, 16'h5001, 16'h1234, 16'h0, 0, 16'hFFFF, 0);
      checks++;
      if (obs_acc_addr !== 16'h5001 || obs_acc_be !== 2'b10 || obs_acc_wdata !== 16'h3434) begin
         errors++; $display("FAIL stb_hi: addr=%h be=%b wdata=%h required 5001/10/3434", obs_acc_addr, obs_acc_be, obs_acc_wdata);
      end
      checks++;
      if (obs_acc_reads !== 0 || obs_acc_writes !== 1) begin
         errors++; $display("FAIL stb_rw: reads=%0d writes=%0d required 0/1", obs_acc_reads, obs_acc_writes);
      end
      exp_q.push_back(16'h0000);
      do_txn(MEM_STB, 16'h5000, 16'h12AB, 16'h0, 0, 16'hFFFF, 0);
      checks++;
      if (obs_acc_addr !== 16'h5000 || obs_acc_be !== 2'b01 || obs_acc_wdata !== 16'hABAB) begin
         errors++; $display("FAIL stb_lo: addr=%h be=%b wdata=%h required 5000/01/ABAB", obs_acc_addr, obs_acc_be, obs_acc_wdata);
      end
      exp_q.push_back(16'h0000);
      do_txn(MEM_STR, 16'h2003, 16'hCAFE, 16'h0, 0, 16'hFFFF, 1);
      checks++;
      if (obs_acc_addr !== 16'h2002 || obs_acc_be !== 2'b11 || obs_acc_wdata !== 16'hCAFE) begin
         errors++; $display("FAIL str: addr=%h be=%b wdata=%h required 2002/11/CAFE", obs_acc_addr, obs_acc_be, obs_acc_wdata);
      end
      checks++;
      if (obs_done_cyc !== 3 || obs_stall_cnt !== 2) begin
         errors++; $display("FAIL str_timing: done=%0d stall=%0d required 3/2", obs_done_cyc, obs_stall_cnt);
      end
   endtask

   task automatic test_indirect;
      exp_q.push_back(16'h00AA);
      do_txn(MEM_LDI, 16'h6000, 16'h0, 16'h7002, 2, 16'h00AA, 2);
      checks++;
      if (obs_ind_addr !== 16'h6000 || obs_acc_addr !== 16'h7002) begin
         errors++; $display("FAIL ldi_addr: ptr_addr=%h acc_addr=%h required 6000/7002", obs_ind_addr, obs_acc_addr);
      end
      checks++;
      if (obs_done_cyc !== 7 || obs_stall_cnt !== 6) begin
         errors++; $display("FAIL ldi_timing: done=%0d stall=%0d required 7/6", obs_done_cyc, obs_stall_cnt);
      end
      exp_q.push_back(16'h0000);
      do_txn(MEM_STI, 16'h6000, 16'h5555, 16'h7000, 0, 16'hFFFF, 0);
      checks++;
      if (obs_acc_addr !== 16'h7000 || obs_acc_be !== 2'b11 || obs_acc_wdata !== 16'h5555) begin
         errors++; $display("FAIL sti: addr=%h be=%b wdata=%h required 7000/11/5555", obs_acc_addr, obs_acc_be, obs_acc_wdata);
      end
      checks++;
      if (obs_acc_reads !== 0 || obs_done_cyc !== 3 || obs_both !== 0) begin
         errors++; $display("FAIL sti_seq: acc_reads=%0d done=%0d both=%0d required 0/3/0", obs_acc_reads, obs_done_cyc, obs_both);
      end
      exp_q.push_back(16'h1111);
      do_txn(MEM_LDI, 16'h6101, 16'h0, 16'h7003, 1, 16'h1111, 0);
      checks++;
      if (obs_ind_addr !== 16'h6100 || obs_acc_addr !== 16'h7002) begin
         errors++; $display("FAIL ldi_align: ptr_addr=%h acc_addr=%h required 6100/7002", obs_ind_addr, obs_acc_addr);
      end
   endtask

   task automatic test_back_to_back;
      exp_q.push_back(16'h0F0F);
      do_txn(MEM_LDR, 16'h1000, 16'h0, 16'h0, 0, 16'h0F0F, 0);
      exp_q.push_back(16'h0000);
      do_txn(MEM_STR, 16'h1002, 16'h4242, 16'h0, 0, 16'hFFFF, 0);
      checks++;
      if (obs_start_stall !== 1'b1 || obs_done_cyc !== 2 || obs_acc_addr !== 16'h1002) begin
         errors++; $display("FAIL b2b: start_stall=%b done=%0d addr=%h required 1/2/1002", obs_start_stall, obs_done_cyc, obs_acc_addr);
      end
   endtask

   task automatic test_no_op;
      valid_in = 1'b1; memop_in = MEM_NONE; addr_in = 16'h1234;
      @(negedge clk);
      checks++;
      if (stall_out !== 1'b0 || done_out !== 1'b0) begin
         errors++; $display("FAIL none_op: stall=%b done=%b required 0/0", stall_out, done_out);
      end
      @(posedge clk); #1;
      valid_in = 1'b0; memop_in = MEM_LDR;
      @(negedge clk);
      checks++;
      if (stall_out !== 1'b0) begin errors++; $display("FAIL invalid_op: stall=%b required 0", stall_out); end
      @(posedge clk); #1;
      memop_in = MEM_NONE;
      checks++;
      if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
         errors++; $display("FAIL invalid_no_req: rd=%b wr=%b required 0/0", dmem_read, dmem_write);
      end
   endtask

   task automatic test_reset_mid;
      valid_in = 1'b1; memop_in = MEM_LDI; addr_in = 16'h6000; dmem_resp = 1'b0;
      @(posedge clk); #1;
      valid_in = 1'b0; memop_in = MEM_NONE;
      @(posedge clk); #1;
      checks++;
      if (dmem_read !== 1'b1 || dmem_address !== 16'h6000) begin
         errors++; $display("FAIL rst_pre: rd=%b addr=%h required 1/6000", dmem_read, dmem_address);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (dmem_read !== 1'b0 || stall_out !== 1'b0 || dmem_address !== 16'h0) begin
         errors++; $display("FAIL rst_async: rd=%b stall=%b addr=%h required 0/0/0000", dmem_read, stall_out, dmem_address);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.push_back(16'h1357);
      do_txn(MEM_LDR, 16'h1235, 16'h0, 16'h0, 0, 16'h1357, 1);
      checks++;
      if (obs_done_cyc !== 3 || obs_acc_addr !== 16'h1234) begin
         errors++; $display("FAIL rst_after_ldr: done=%0d addr=%h required 3/1234", obs_done_cyc, obs_acc_addr);
      end
      dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL stray_resp[%0d]: done=%b stall=%b required 0/0", i, done_out, stall_out);
         end
         @(posedge clk); #1;
      end
      dmem_resp = 1'b0;
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; memop_in = MEM_NONE;
      addr_in = '0; wdata_in = '0; dmem_rdata = '0; dmem_resp = 1'b0;
      test_reset();
      test_ldr();
      test_ldb();
      test_stores();
      test_indirect();
      test_back_to_back();
      test_no_op();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: %0d pending completions required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-access stage controller for the pipelined LC-3b datapath. It sits directly downstream of the execute side of the pipeline and consumes the memory operation, effective address and store data carried in the EX/MEM pipeline register. It sequences single- and double-access data-memory transactions (LDR/LDB/STR/STB, plus indirect LDI/STI) over a request/response handshake. It raises a stall that freezes every upstream pipeline register until the access completes.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- valid_in  in  1  EX/MEM register holds a live instruction
- memop_in  in  lc3b_memop  MEM_NONE, MEM_LDR, MEM_LDB, MEM_STR, MEM_STB, MEM_LDI, MEM_STI
- addr_in  in  lc3b_word  effective address from execute
- wdata_in  in  lc3b_word  store data (SR contents)
- dmem_rdata  in  lc3b_word  data-memory read word
- dmem_resp  in  1  data memory completes current request this cycle
- dmem_address  out  lc3b_word  request address
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_byte_enable  out  2  byte lanes for writes
- dmem_wdata  out  lc3b_word  write data
- stall_out  out  1  freeze upstream pipeline registers
- mem_data_out  out  lc3b_word  load result, valid when done_out=1
- done_out  out  1  memory instruction completes this cycle

## Operation
- States: S_IDLE, S_IND (indirect pointer read), S_ACC (final access).
- start = valid_in & (memop_in != MEM_NONE), evaluated only in S_IDLE.
- S_IDLE with start:
  - Latch memop_in, addr_in and wdata_in into op_reg, addr_reg and wdata_reg.
  - Next state is S_IND for LDI/STI; S_ACC otherwise.
- S_IDLE without start: remain. dmem_resp is ignored.
- S_IND:
  - dmem_read=1, dmem_address={addr_reg[15:1],1'b0}.
  - On dmem_resp: addr_reg <= {dmem_rdata[15:1],1'b0}; go to S_ACC.
  - Otherwise hold.
- S_ACC, loads (LDR/LDB/LDI):
  - dmem_read=1.
  - dmem_address is addr_reg, with bit 0 cleared for word ops.
- S_ACC, stores (STR/STI):
  - dmem_write=1, dmem_byte_enable=2'b11, dmem_wdata=wdata_reg.
- S_ACC, STB:
  - dmem_write=1, dmem_wdata={wdata_reg[7:0],wdata_reg[7:0]}.
  - dmem_byte_enable=2'b10 if addr_reg[0], else 2'b01.
- S_ACC with dmem_resp: done_out=1 and go to S_IDLE.
  - Word load: mem_data_out = dmem_rdata.
  - LDB: mem_data_out = sign-extended selected byte (high byte if addr_reg[0]).
  - Stores: mem_data_out = 0.
- stall_out = (S_IDLE & start) | (S_IND) | (S_ACC & ~dmem_resp).
- dmem_read and dmem_write are never high together. Both are 0 in S_IDLE; dmem_byte_enable is 0 when not writing.
- Misaligned word addresses are silently aligned (bit 0 dropped); no exception.

## Timing
- Reset values: state S_IDLE; all latched registers 0; every output 0.
- Reset mid-transaction:
  - Request outputs deassert asynchronously and the access is abandoned.
  - No done_out is produced.
- Request outputs are functions of registered state only. They stay stable until dmem_resp.
- Latency from the start cycle to done_out, with zero-wait memory (resp in the first request cycle):
  - LDR/LDB/STR/STB: 2 cycles.
  - LDI/STI: 3 cycles.
  - Each wait cycle adds 1.
- done_out is asserted in the same cycle stall_out falls. Upstream registers advance at that edge, and the next instruction is evaluated in S_IDLE on the following cycle.
- Back-to-back memory ops: one S_IDLE cycle separates transactions; no bubble is inserted downstream beyond the stall.
- valid_in=0 or MEM_NONE: stall_out=0, done_out=0, zero-cycle pass.

## Structure
- Shared package lc3b_types:
  - typedef enum lc3b_memop, listing the seven values above.
  - Reuse lc3b_word.
- State enum is local to the module.
- Optional sub-module mem_byte_align: combinational LDB extraction/sign-extension and STB lane replication. Everything else is inline.

## Test plan
- LDR addr 0x3001, resp on first request cycle, rdata 0xBEEF:
  - dmem_address 0x3000, dmem_read=1 for 1 cycle.
  - done_out with mem_data_out 0xBEEF 2 cycles after start.
  - stall high exactly 1 cycle.
- LDB addr 0x4003, rdata 0x80FF → mem_data_out 0xFF80. LDB addr 0x4002, same rdata → 0xFFFF.
- STB addr 0x5001, wdata 0x1234:
  - dmem_write=1, byte_enable 2'b10, dmem_wdata 0x3434, dmem_address 0x5001.
  - dmem_read stays 0.
- LDI addr 0x6000, resp rdata 0x7002, then second resp rdata 0x00AA, with 2 wait cycles on each access:
  - Second address is 0x7002.
  - done_out carries 0x00AA at cycle 7; stall_out high cycles 1–6.
- STI addr 0x6000 → pointer 0x7000; wdata 0x5555 written with byte_enable 2'b11; no read in S_ACC.
- Reset asserted in S_IND mid-wait:
  - dmem_read drops immediately and the state is S_IDLE.
  - A subsequent LDR completes normally.
  - A stray dmem_resp while in S_IDLE produces no done_out.
